// File: rtl/usb_device_protocol.sv
// usb_device_protocol
//   Device-side USB transaction responder. Decodes host tokens addressed to
//   DEV_ADDR/ENDP, accepts OUT data and answers ACK/NAK, and answers IN tokens
//   with the application payload, retrying on NAK/timeout up to MAX_RETRY sends.
//
// Ports
//   clk, rst_b        clock, synchronous active-low reset
//   pktInDC[98:0]     decoded host packet (sync, token/handshake word, data field)
//   validDC           packet passed CRC/format checks (qualified by pktInAvailDC)
//   pktInAvailDC      one-cycle strobe: new packet on pktInDC
//   readyEC           encoder can accept pktOut
//   pktOut[98:0]      packet to encoder, stable while pktOutAvail
//   pktOutAvail       pktOut valid, held until readyEC
//   txData[63:0]      IN payload from application
//   txDataValid       txData loaded
//   rxReady           application can accept an OUT payload
//   rxData[63:0]      last accepted OUT payload
//   rxDataValid       pulse: ACK for new rxData has been handed to the encoder
//   txDone            pulse: host ACKed IN data
//   txFail            pulse: IN abandoned after MAX_RETRY sends
//   busy              FSM not in Idle
//
// The result pulses (rxDataValid, txDone, txFail) are registered, so they
// appear in the cycle following the edge that completes the transaction.
module usb_device_protocol #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] ENDP      = 4'd4,
  parameter logic [7:0] DATA_PID  = 8'hC3,
  parameter int         TIMEOUT   = 255,
  parameter int         MAX_RETRY = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [98:0] pktInDC,
  input  logic        validDC,
  input  logic        pktInAvailDC,
  input  logic        readyEC,
  output logic [98:0] pktOut,
  output logic        pktOutAvail,
  input  logic [63:0] txData,
  input  logic        txDataValid,
  input  logic        rxReady,
  output logic [63:0] rxData,
  output logic        rxDataValid,
  output logic        txDone,
  output logic        txFail,
  output logic        busy
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMEOUT_V   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX   = '1;
  localparam logic [RW-1:0] MAX_RETRY_V = RW'(MAX_RETRY);
  localparam logic [18:0]   ACK_WORD    = 19'h00A58;
  localparam logic [18:0]   NAK_WORD    = 19'h00A50;
  localparam logic [98:0]   ACK_PKT     = {8'h01, ACK_WORD, 72'd0};
  localparam logic [98:0]   NAK_PKT     = {8'h01, NAK_WORD, 72'd0};

  typedef enum logic [2:0] {
    IDLE, RX_DATA, SEND_ACK, SEND_NAK, SEND_DATA, WAIT_HS
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;

  logic pkt_ok, addr_hit, is_out, is_in, data_ok, ack_ok, timed_out, xfer;

  assign pkt_ok    = pktInAvailDC && validDC;
  assign addr_hit  = (pktInDC[82:76] == DEV_ADDR) && (pktInDC[75:72] == ENDP);
  assign is_out    = pkt_ok && addr_hit && (pktInDC[90:87] == 4'b1000);
  assign is_in     = pkt_ok && addr_hit && (pktInDC[90:87] == 4'b1001);
  assign data_ok   = pkt_ok && (pktInDC[90:83] == DATA_PID);
  assign ack_ok    = pkt_ok && (pktInDC[90:72] == ACK_WORD);
  assign timed_out = (timer == TIMEOUT_V);
  assign xfer      = pktOutAvail && readyEC;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      pktOut      <= '0;
      pktOutAvail <= 1'b0;
      rxData      <= '0;
      rxDataValid <= 1'b0;
      txDone      <= 1'b0;
      txFail      <= 1'b0;
      timer       <= '0;
      retry       <= '0;
    end else begin
      rxDataValid <= 1'b0;
      txDone      <= 1'b0;
      txFail      <= 1'b0;
      case (state)
        IDLE: begin
          if (is_out) begin
            state <= RX_DATA;
            timer <= '0;
          end else if (is_in) begin
            pktOutAvail <= 1'b1;
            if (txDataValid) begin
              state  <= SEND_DATA;
              pktOut <= {8'h01, DATA_PID, txData, 19'd0};
              retry  <= '0;
            end else begin
              state  <= SEND_NAK;
              pktOut <= NAK_PKT;
            end
          end
        end
        RX_DATA: begin
          // A packet in the timeout cycle wins over the timeout.
          if (pktInAvailDC) begin
            if (data_ok) begin
              pktOutAvail <= 1'b1;
              if (rxReady) begin
                rxData <= pktInDC[82:19];
                pktOut <= ACK_PKT;
                state  <= SEND_ACK;
              end else begin
                pktOut <= NAK_PKT;
                state  <= SEND_NAK;
              end
            end else begin
              state <= IDLE;
            end
          end else if (timed_out) begin
            state <= IDLE;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        SEND_ACK: begin
          if (xfer) begin
            state       <= IDLE;
            pktOutAvail <= 1'b0;
            rxDataValid <= 1'b1;
          end
        end
        SEND_NAK: begin
          if (xfer) begin
            state       <= IDLE;
            pktOutAvail <= 1'b0;
          end
        end
        SEND_DATA: begin
          if (xfer) begin
            state       <= WAIT_HS;
            pktOutAvail <= 1'b0;
            timer       <= '0;
            retry       <= retry + 1'b1;
          end
        end
        WAIT_HS: begin
          // pktOut still holds the data packet, so a retry simply re-raises
          // pktOutAvail with the same latched payload.
          if (pktInAvailDC || timed_out) begin
            if (ack_ok) begin
              state  <= IDLE;
              txDone <= 1'b1;
            end else if (retry < MAX_RETRY_V) begin
              state       <= SEND_DATA;
              pktOutAvail <= 1'b1;
            end else begin
              state  <= IDLE;
              txFail <= 1'b1;
            end
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          pktOutAvail <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_device_protocol.sv
module tb_usb_device_protocol;

  logic        clk;
  logic        rst_b;
  logic [98:0] pktInDC;
  logic        validDC;
  logic        pktInAvailDC;
  logic        readyEC;
  logic [98:0] pktOut;
  logic        pktOutAvail;
  logic [63:0] txData;
  logic        txDataValid;
  logic        rxReady;
  logic [63:0] rxData;
  logic        rxDataValid;
  logic        txDone;
  logic        txFail;
  logic        busy;

  usb_device_protocol dut (
    .clk(clk), .rst_b(rst_b), .pktInDC(pktInDC), .validDC(validDC),
    .pktInAvailDC(pktInAvailDC), .readyEC(readyEC), .pktOut(pktOut),
    .pktOutAvail(pktOutAvail), .txData(txData), .txDataValid(txDataValid),
    .rxReady(rxReady), .rxData(rxData), .rxDataValid(rxDataValid),
    .txDone(txDone), .txFail(txFail), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int EV_PKT  = 0;
  localparam int EV_RX   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_FAIL = 3;

  localparam logic [7:0]  PID_OUT = 8'h87;
  localparam logic [7:0]  PID_IN  = 8'h96;
  localparam logic [98:0] HS_ACK  = {8'h01, 19'h00A58, 72'd0};
  localparam logic [98:0] HS_NAK  = {8'h01, 19'h00A50, 72'd0};

  typedef struct {
    int          kind;
    logic [98:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [98:0] tok(input logic [7:0] pid, input logic [6:0] a,
                                      input logic [3:0] e);
    return {8'h01, pid, a, e, 72'd0};
  endfunction

  function automatic logic [98:0] dpkt(input logic [7:0] pid, input logic [63:0] p);
    return {8'h01, pid, p, 19'd0};
  endfunction

  task automatic push(input int kind, input logic [98:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [98:0] act, input logic [98:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send_pkt(input logic [98:0] p, input logic v);
    pktInDC      = p;
    validDC      = v;
    pktInAvailDC = 1'b1;
    tick();
    pktInAvailDC = 1'b0;
    validDC      = 1'b0;
  endtask

  task automatic wait_avail(input int lim, output int n);
    n = 0;
    while (!pktOutAvail && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (!pktOutAvail) begin
      errors++;
      $display("FAIL wait_avail: pktOutAvail still 0 after %0d cycles, expected 1", n);
    end
  endtask

  // Scoreboard monitor: every output event the DUT presents is matched
  // against the next expected entry.
  task automatic mon_evt(input int kind, input logic [98:0] val, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind %0d value %h, expected none", name, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        errors++;
        $display("FAIL %s: got kind %0d value %h expected kind %0d value %h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (pktOutAvail && readyEC) mon_evt(EV_PKT, pktOut, "pkt_out");
        if (rxDataValid) mon_evt(EV_RX, {35'd0, rxData}, "rx_data");
        if (txDone) mon_evt(EV_DONE, 99'd0, "tx_done");
        if (txFail) mon_evt(EV_FAIL, 99'd0, "tx_fail");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [98:0] dexp;
    rst_b = 1'b0; pktInDC = '0; validDC = 1'b0; pktInAvailDC = 1'b0;
    readyEC = 1'b1; txData = '0; txDataValid = 1'b0; rxReady = 1'b1;
    ticks(3);
    rst_b = 1'b1;
    tick();
    chk("reset_pktOut", pktOut, 99'd0);
    chk("reset_flags", {95'd0, pktOutAvail, rxDataValid, txDone, txFail}, 99'd0);
    chk("reset_rxData", {35'd0, rxData}, 99'd0);
    chk("reset_busy", {98'd0, busy}, 99'd0);

    // OUT transaction, application ready -> ACK and payload delivered
    push(EV_PKT, HS_ACK);
    push(EV_RX, {35'd0, 64'hDEADBEEF_01234567});
    send_pkt(tok(PID_OUT, 7'd5, 4'd4), 1'b1);
    chk("out_busy", {98'd0, busy}, 99'd1);
    send_pkt(dpkt(8'hC3, 64'hDEADBEEF_01234567), 1'b1);
    ticks(4);
    chk("out_ack_idle", {98'd0, busy}, 99'd0);
    chk("out_ack_rxData", {35'd0, rxData}, {35'd0, 64'hDEADBEEF_01234567});

    // OUT transaction, application not ready -> NAK, rxData kept
    rxReady = 1'b0;
    push(EV_PKT, HS_NAK);
    send_pkt(tok(PID_OUT, 7'd5, 4'd4), 1'b1);
    send_pkt(dpkt(8'hC3, 64'h1111_2222_3333_4444), 1'b1);
    ticks(4);
    chk("out_nak_rxData", {35'd0, rxData}, {35'd0, 64'hDEADBEEF_01234567});
    chk("out_nak_idle", {98'd0, busy}, 99'd0);
    rxReady = 1'b1;

    // IN transaction with encoder stalled for 10 cycles
    readyEC = 1'b0; txData = 64'hA5A5_A5A5_A5A5_A5A5; txDataValid = 1'b1;
    dexp = dpkt(8'hC3, 64'hA5A5_A5A5_A5A5_A5A5);
    send_pkt(tok(PID_IN, 7'd5, 4'd4), 1'b1);
    txData = 64'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_avail", {98'd0, pktOutAvail}, 99'd1);
      chk("stall_pktOut", pktOut, dexp);
      tick();
    end
    push(EV_PKT, dexp);
    push(EV_DONE, 99'd0);
    readyEC = 1'b1;
    tick();
    send_pkt(HS_ACK, 1'b1);
    ticks(3);
    chk("in_ack_idle", {98'd0, busy}, 99'd0);

    // IN transaction, host NAKs every attempt -> 8 sends then txFail
    txData = 64'h0123_4567_89AB_CDEF;
    dexp = dpkt(8'hC3, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 8; i++) push(EV_PKT, dexp);
    push(EV_FAIL, 99'd0);
    send_pkt(tok(PID_IN, 7'd5, 4'd4), 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_avail(10, n);
      tick();
      send_pkt(HS_NAK, 1'b1);
    end
    ticks(3);
    chk("nak_fail_idle", {98'd0, busy}, 99'd0);
    chk("nak_fail_queue", 99'(exp_q.size()), 99'd0);

    // IN transaction, host silent -> 8 sends spaced by timeouts, then txFail
    txData = 64'hFEDC_BA98_7654_3210;
    dexp = dpkt(8'hC3, 64'hFEDC_BA98_7654_3210);
    for (int i = 0; i < 8; i++) push(EV_PKT, dexp);
    push(EV_FAIL, 99'd0);
    send_pkt(tok(PID_IN, 7'd5, 4'd4), 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_avail(300, n);
      if (i > 0) begin
        checks++;
        if (n < 255 || n > 257) begin
          errors++;
          $display("FAIL timeout_spacing: got %0d cycles expected 255..257", n);
        end
      end
      tick();
    end
    ticks(300);
    chk("tmo_fail_idle", {98'd0, busy}, 99'd0);
    chk("tmo_fail_queue", 99'(exp_q.size()), 99'd0);

    // Tokens that must be ignored
    send_pkt(tok(PID_IN, 7'd6, 4'd4), 1'b1);
    ticks(2);
    chk("bad_addr", {97'd0, busy, pktOutAvail}, 99'd0);
    send_pkt(tok(PID_IN, 7'd5, 4'd3), 1'b1);
    ticks(2);
    chk("bad_ep", {97'd0, busy, pktOutAvail}, 99'd0);
    send_pkt(tok(PID_IN, 7'd5, 4'd4), 1'b0);
    ticks(2);
    chk("invalid_tok", {97'd0, busy, pktOutAvail}, 99'd0);

    // OUT token followed by corrupt / wrong-PID data -> silently back to Idle
    send_pkt(tok(PID_OUT, 7'd5, 4'd4), 1'b1);
    send_pkt(dpkt(8'hC3, 64'h5555_5555_5555_5555), 1'b0);
    ticks(2);
    chk("corrupt_data", {97'd0, busy, pktOutAvail}, 99'd0);
    send_pkt(tok(PID_OUT, 7'd5, 4'd4), 1'b1);
    send_pkt(dpkt(8'h4B, 64'h6666_6666_6666_6666), 1'b1);
    ticks(2);
    chk("wrong_pid_data", {97'd0, busy, pktOutAvail}, 99'd0);
    chk("wrong_pid_rxData", {35'd0, rxData}, {35'd0, 64'hDEADBEEF_01234567});

    // Reset during WaitHs, then a normal IN transaction
    txData = 64'h0F0F_0F0F_0F0F_0F0F;
    dexp = dpkt(8'hC3, 64'h0F0F_0F0F_0F0F_0F0F);
    push(EV_PKT, dexp);
    send_pkt(tok(PID_IN, 7'd5, 4'd4), 1'b1);
    wait_avail(10, n);
    tick();
    ticks(3);
    rst_b = 1'b0;
    tick();
    chk("rst_mid_pktOut", pktOut, 99'd0);
    chk("rst_mid_flags", {94'd0, busy, pktOutAvail, rxDataValid, txDone, txFail}, 99'd0);
    chk("rst_mid_rxData", {35'd0, rxData}, 99'd0);
    rst_b = 1'b1;
    tick();
    txData = 64'h1234_5678_9ABC_DEF0;
    dexp = dpkt(8'hC3, 64'h1234_5678_9ABC_DEF0);
    push(EV_PKT, dexp);
    push(EV_DONE, 99'd0);
    send_pkt(tok(PID_IN, 7'd5, 4'd4), 1'b1);
    wait_avail(10, n);
    tick();
    send_pkt(HS_ACK, 1'b1);
    ticks(5);
    chk("post_rst_idle", {98'd0, busy}, 99'd0);
    chk("final_queue", 99'(exp_q.size()), 99'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_device_protocol.md
Name: usb_device_protocol

Overview:
- Device-side (responder) USB transaction engine. Opposite end of the host protocol FSM on the same link.
- Sits between the packet decoder (incoming host packets) and the packet encoder (outgoing device packets).
- OUT token: accepts the host DATA packet and answers ACK or NAK.
- IN token: sends the application's 64-bit payload, waits for the host handshake, and retries on NAK or timeout.

Parameters:
- DEV_ADDR, 7'd5, device address matched against token bits [10:4]
- ENDP, 4'd4, endpoint matched against token bits [3:0]
- DATA_PID, 8'hC3, PID byte placed in and expected on data packets
- TIMEOUT, 255, cycles waited in RxData/WaitHs before timeout
- MAX_RETRY, 8, IN data transmissions before giving up

Ports:
- clk  in  1  clock
- rst_b  in  1  synchronous active-low reset
- pktInDC  in  99  decoded packet: [98:91] sync, [90:72] token/handshake word, [90:19] data field (PID [90:83], payload [82:19])
- validDC  in  1  packet passed CRC/format checks; qualified by pktInAvailDC
- pktInAvailDC  in  1  one-cycle strobe, new packet on pktInDC
- readyEC  in  1  encoder can take a packet
- pktOut  out  99  packet to encoder
- pktOutAvail  out  1  pktOut valid; held until readyEC
- txData  in  64  IN payload from application
- txDataValid  in  1  txData loaded, IN may be answered with data
- rxReady  in  1  application can accept OUT payload
- rxData  out  64  last accepted OUT payload
- rxDataValid  out  1  one-cycle pulse, new rxData
- txDone  out  1  one-cycle pulse, host ACKed IN data
- txFail  out  1  one-cycle pulse, IN abandoned after MAX_RETRY attempts
- busy  out  1  state != Idle

Behaviour:
- Reset (rst_b low at posedge): state=Idle; pktOut=0; pktOutAvail=0; rxData=0; rxDataValid=0; txDone=0; txFail=0; timer=0; retry count=0. Reset mid-transaction aborts it and emits nothing.
- Constants:
  - ACK word = 19'h00A58; NAK word = 19'h00A50.
  - Handshake out = {8'h01, word, 72'd0}.
  - Data out = {8'h01, DATA_PID, txData latched, 19'd0}.
- Token decode:
  - Only when pktInAvailDC && validDC.
  - PID nibble = pktInDC[90:87]: 4'b1000 = OUT, 4'b1001 = IN.
  - Address and endpoint must match the parameters; anything else is ignored.
- Encoder handshake:
  - In a Send state, pktOutAvail=1 and pktOut is stable from state entry.
  - Transfer occurs at the posedge where pktOutAvail && readyEC; the FSM leaves the state on that edge.
  - pktOutAvail=0 in all other states.
- States:
  - Idle:
    - OUT token -> RxData, timer cleared.
    - IN token && txDataValid -> SendData: latch txData, retry=0.
    - IN token && !txDataValid -> SendNak.
    - Any other packet: stay in Idle.
  - RxData:
    - Valid packet with pktInDC[90:83]==DATA_PID && rxReady -> latch payload into rxData, go to SendAck.
    - Same but !rxReady -> SendNak; rxData unchanged.
    - Invalid packet (validDC=0) -> Idle, no response.
    - Timer==TIMEOUT -> Idle.
    - A valid packet with the wrong PID is treated as invalid.
  - SendAck: on transfer -> Idle; rxDataValid pulses on the transfer cycle.
  - SendNak: on transfer -> Idle.
  - SendData: on transfer -> WaitHs, timer cleared, retry += 1.
  - WaitHs:
    - Valid ACK word at [90:72] -> Idle, txDone pulse.
    - NAK, invalid packet, or timeout, with retry < MAX_RETRY -> SendData (same latched payload).
    - Same with retry == MAX_RETRY -> Idle, txFail pulse.
- Timer: 8-bit minimum. Cleared on entry to RxData/WaitHs; increments each cycle in those states; saturates, no wrap.
- Simultaneous packet strobe and timeout in the same cycle: the packet is processed; the timeout is ignored.
- Tokens arriving in non-Idle states are ignored. No data toggle: DATA_PID is fixed.

Test Plan:
- OUT token addr 5/ep 4, then valid DATA payload 64'hDEADBEEF_01234567, rxReady=1, readyEC=1 -> pktOut={8'h01,19'h00A58,72'd0}; rxData=DEADBEEF01234567; rxDataValid high 1 cycle; back to Idle.
- Same with rxReady=0 -> NAK packet {8'h01,19'h00A50,72'd0}; rxDataValid never asserted; rxData unchanged.
- IN token, txDataValid=1, txData=64'hA5A5..., readyEC held low 10 cycles -> pktOutAvail high and pktOut stable for all 10 cycles. Then readyEC=1 and host ACK -> txDone pulse, Idle.
- IN token, host NAKs every response -> exactly 8 data packets sent, then txFail pulse, Idle. Repeat with no host response -> 8 sends spaced by 255-cycle timeouts, then txFail.
- Token with addr 6 or ep 3, or validDC=0 -> no pktOutAvail, state stays Idle. OUT token then corrupt data -> no handshake, Idle.
- rst_b low for one cycle during WaitHs -> next cycle all outputs 0, state Idle; a following IN token is serviced normally.
